// File: rtl/posit_align_acc.sv
// Align-and-accumulate stage: shifts each signed product to the accumulator exponent,
// adds it into a saturating accumulator, and hands off the result at end of vector.
module posit_align_acc #(
    parameter int ACC_W  = 32,
    parameter int FRAC_W = 14,
    parameter int EXP_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [EXP_W-1:0]  exp_set,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [FRAC_W-1:0] frac_in,
    input  logic              zero_in,
    input  logic              nar_in,
    input  logic              last_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              nar_out,
    output logic              ovf_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Wide enough to hold frac_in at the largest possible left shift.
    localparam int SH_W = (FRAC_W + (1 << EXP_W) > ACC_W) ? (FRAC_W + (1 << EXP_W)) : ACC_W;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              nar_q, nar_d;
    logic              ovf_q, ovf_d;

    logic              s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]  s1_mag_q, s1_mag_d;
    logic              s1_sov_q, s1_sov_d;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_zero_q, s1_zero_d;
    logic              s1_nar_q, s1_nar_d;
    logic              s1_last_q, s1_last_d;

    logic [EXP_W-1:0]    exp_cur;
    logic signed [EXP_W:0] diff;
    logic [EXP_W:0]      rshift;
    logic [SH_W-1:0]     lsh;
    logic [FRAC_W-1:0]   rsh;
    logic [ACC_W-1:0]    al_mag;
    logic                al_sov;
    logic [ACC_W:0]      sum;
    logic                accept;
    logic                handoff;

    assign in_ready  = (state_q == ST_ACC);
    assign res_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign handoff   = res_valid && res_ready && !clr;

    assign acc_out   = acc_q;
    assign exp_out   = exp_q;
    assign count_out = cnt_q;
    assign nar_out   = nar_q;
    assign ovf_out   = ovf_q;

    // An element accepted alongside clr aligns to the incoming exp_set.
    always_comb begin
        exp_cur = clr ? exp_set : exp_q;
        diff    = $signed({1'b0, exp_in}) - $signed({1'b0, exp_cur});
        rshift  = $unsigned(-diff);
        lsh     = SH_W'(frac_in) << diff[EXP_W-1:0];
        rsh     = frac_in >> rshift;
        if (!diff[EXP_W]) begin
            al_mag = lsh[ACC_W-1:0];
            al_sov = |lsh[SH_W-1:ACC_W-1];
        end else begin
            al_mag = ACC_W'(rsh);
            al_sov = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_mag_d   = s1_mag_q;
        s1_sov_d   = s1_sov_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_nar_d   = s1_nar_q;
        s1_last_d  = s1_last_q;
        if (accept) begin
            s1_mag_d  = al_mag;
            s1_sov_d  = al_sov;
            s1_sign_d = sign_in;
            s1_zero_d = zero_in;
            s1_nar_d  = nar_in;
            s1_last_d = last_in;
        end
    end

    // One guard bit catches signed overflow of the add/subtract.
    assign sum = s1_sign_q ? ({acc_q[ACC_W-1], acc_q} - {1'b0, s1_mag_q})
                           : ({acc_q[ACC_W-1], acc_q} + {1'b0, s1_mag_q});

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nar_d   = nar_q;
        ovf_d   = ovf_q;

        if (s1_valid_q) begin
            if (s1_nar_q) nar_d = 1'b1;
            if (s1_zero_q) begin
                acc_d = acc_q;
            end else if (s1_sov_q) begin
                acc_d = s1_sign_q ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        if (accept) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE:  state_d = ST_ACC;
            ST_ACC:   if (accept && last_in) state_d = ST_DRAIN;
            ST_DRAIN: if (s1_valid_q && s1_last_q) state_d = ST_HOLD;
            ST_HOLD:  if (res_ready) state_d = ST_ACC;
            default:  state_d = ST_IDLE;
        endcase

        if (handoff) begin
            acc_d = '0;
            cnt_d = '0;
            nar_d = 1'b0;
            ovf_d = 1'b0;
        end

        // clr overrides everything; a last element accepted with it still drains to a result.
        if (clr) begin
            acc_d   = '0;
            nar_d   = 1'b0;
            ovf_d   = 1'b0;
            exp_d   = exp_set;
            cnt_d   = accept ? CNT_W'(1) : '0;
            state_d = (accept && last_in) ? ST_DRAIN : ST_ACC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            nar_q      <= 1'b0;
            ovf_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_sov_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            nar_q      <= nar_d;
            ovf_q      <= ovf_d;
            s1_valid_q <= s1_valid_d;
            s1_mag_q   <= s1_mag_d;
            s1_sov_q   <= s1_sov_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_nar_q   <= s1_nar_d;
            s1_last_q  <= s1_last_d;
        end
    end

endmodule

// File: doc/posit_align_acc.md
# posit_align_acc

Parametrised, pipelined align-and-accumulate stage for the FP/posit MAC datapath. It sits downstream of the multiplier/decoder and consumes a stream of signed fixed-point products, each carrying its own exponent. Each product is aligned to a per-dot-product accumulator exponent and added into a saturating two's-complement accumulator. It adds what the single-shot accumulator lacked: width parameters, a valid/ready stream, end-of-vector result handoff, saturation, and sticky NaR/overflow flags.

## Interface
- ACC_W, 32, accumulator width (signed two's complement)
- FRAC_W, 14, unsigned magnitude width of incoming product
- EXP_W, 5, unsigned exponent width
- CNT_W, 16, element counter width
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-low
- clr  in  1  synchronous clear; latches exp_set
- exp_set  in  EXP_W  accumulator exponent, sampled only on clr
- in_valid  in  1  product valid
- in_ready  out  1  block accepts a product this cycle
- sign_in  in  1  1 = subtract
- exp_in  in  EXP_W  product exponent
- frac_in  in  FRAC_W  product magnitude
- zero_in  in  1  product is zero; counted but adds nothing
- nar_in  in  1  product is NaR
- last_in  in  1  final element of the vector
- res_valid  out  1  result held
- res_ready  in  1  result consumed
- acc_out  out  ACC_W  accumulator value
- exp_out  out  EXP_W  latched accumulator exponent
- count_out  out  CNT_W  elements accepted since clear or handoff; wraps modulo 2^CNT_W
- nar_out  out  1  sticky NaR
- ovf_out  out  1  sticky saturation

## Operation
- Accept condition: in_valid && in_ready. in_ready = (state == ACC), registered.
- Stage 1 (accept edge):
  - diff = exp_in − exp_cur, computed signed in EXP_W+1 bits. exp_cur is exp_set when clr is high in the same cycle, otherwise the latched exponent.
  - diff ≥ 0: mag = frac_in << diff into an ACC_W field. If any set bit reaches bit ACC_W−1 or above, mark the element shift-overflow.
  - diff < 0: mag = frac_in >> −diff, truncating. A shift of FRAC_W or more gives 0.
  - Register mag, sign, zero, nar, last and the shift-overflow mark.
- Stage 2 (next edge):
  - zero: acc is unchanged.
  - shift-overflow: acc saturates to 2^(ACC_W−1)−1 if sign = 0, or −2^(ACC_W−1) if sign = 1. Set ovf.
  - Otherwise: sum = acc ± mag in ACC_W+1 bits. On signed overflow, clamp to max/min and set ovf.
  - nar: set nar_out. Accumulation still proceeds.
- count increments at the accept edge, including zero and NaR elements.
- State machine:
  - ACC → DRAIN when an element with last_in = 1 is accepted.
  - DRAIN → HOLD on the next edge, when that element is accumulated. res_valid is 1 in HOLD only.
  - HOLD → ACC on res_valid && res_ready. On that edge acc, count, nar_out and ovf_out clear to 0; exp_out holds its value.
- clr, from any state:
  - Next state ACC. acc, count, nar and ovf clear to 0; exp_out ← exp_set.
  - Any element in stage 1 is discarded.
  - An element accepted in the clr cycle is aligned to the new exp_set, accumulates onto 0, and counts as 1.
  - A clr in HOLD drops the pending result.
- Input fields are ignored when no accept occurs.

## Timing
- Reset values: in_ready=0 during reset and 1 from the first edge after reset release (state ACC); res_valid=0; acc_out=0; exp_out=0; count_out=0; nar_out=0; ovf_out=0.
- Latency: element accepted at edge T appears in acc_out after edge T+1. Full throughput of 1 element/cycle in ACC.
- Flags: nar_out and ovf_out update at T+1. count_out updates at T.
- Result timing: last accepted at T gives res_valid=1 after edge T+1. in_ready=0 from after T until after the handoff edge.
- Result hold: acc_out, count_out and the flags are stable while res_valid=1.
- Simultaneous clr and res_ready in HOLD: clr wins and no handoff occurs. The outcome is identical, except exp_out loads the new value.
- Reset asserted mid-operation clears all state immediately, without waiting for an edge.

## Test plan
- Basic add/subtract: clr with exp_set=10, then (exp 10, frac 0x1000, +), then (exp 12, frac 0x0100, −, last). Required: acc_out=0xC00, count_out=2, res_valid=1 two edges after the last accept, in_ready=0 until res_ready.
- Right shift: exp_set=10, then (exp 7, frac 0x0009, +) gives acc 0x1. Then clr with exp_set=20 and (exp 0, frac 0x3FFF): acc stays 0.
- Saturation, shift overflow: exp_set=0, (exp 31, frac 0x3FFF, +) gives acc 0x7FFFFFFF, ovf=1. The same with sign=1 after clr gives 0x80000000.
- Saturation, sum overflow: accumulate to 0x7FFFFF00, then add 0x100. Required: acc holds 0x7FFFFFFF, ovf=1.
- Flags and handshake: a NaR element sets nar_out=1 one edge later. A zero element with frac 0x3FFF leaves acc unchanged but increments count. In HOLD, res_ready=0 for 5 cycles: res_valid, acc_out and nar_out hold, and in_valid is ignored. When res_ready=1, the next cycle shows acc=0, nar=0, count=0, in_ready=1.
- Clear and reset mid-operation: clr together with an accepted element (exp_set=3, exp 3, frac 0x5) while a prior element is in stage 1. Required: acc=0x5 and count=1; the prior element is lost. Async rst asserted mid-stream zeroes all outputs without waiting for an edge.
